// File: rtl/drum_pkg.sv
// Shared definitions for drum_trigger_seq: the register map, the CTRL/STATUS bit positions,
// the pulse FSM state type and the byte-enable merge helper.
package drum_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_WIDTH  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_FIRE = 0;
    localparam int CTRL_LOOP = 1;
    localparam int CTRL_IRQ  = 2;

    localparam int STAT_ACTIVE = 0;
    localparam int STAT_RUN    = 1;
    localparam int STAT_PEND   = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_t;

    // Replace only the enabled byte lanes of a 32-bit register image.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/drum_channel.sv
// One trigger channel: CTRL/PERIOD/WIDTH registers, loop phase counter and strike pulse FSM.
// With DRUM_IRQ_EN defined the channel also keeps an IRQ enable and an IRQ pending flag.
module drum_channel
    import drum_pkg::*;
#(
    parameter int WIDTH_W   = 16,
    parameter int PERIOD_W  = 16,
    parameter int DEF_WIDTH = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic [31:0] rd_data,
`ifdef DRUM_IRQ_EN
    output logic        pending,
`endif
    output logic        strike
);

    localparam logic [WIDTH_W-1:0]  W_ZERO = {WIDTH_W{1'b0}};
    localparam logic [WIDTH_W-1:0]  W_ONE  = {{(WIDTH_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] P_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] P_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

    logic                loop_en_r;
    logic [PERIOD_W-1:0] period_r;
    logic [PERIOD_W-1:0] phase_r;
    logic [WIDTH_W-1:0]  width_r;
    logic [WIDTH_W-1:0]  count_r;
    logic [WIDTH_W-1:0]  load_s;
    pulse_state_t        state_r;

    logic wr_ctrl_s;
    logic wr_period_s;
    logic wr_width_s;
    logic period_nz_s;
    logic running_s;
    logic fire_cmd_s;
    logic loop_start_s;
    logic loop_stop_s;
    logic wrap_s;
    logic loop_strike_s;
    logic fire_s;

`ifdef DRUM_IRQ_EN
    logic irq_en_r;
    logic irq_en_eff_s;
    logic pending_r;
    logic wr_status_s;
`endif

    // Write strobes and the two fire sources (manual FIRE, loop strike).
    always_comb begin
        wr_ctrl_s     = wr_en && (reg_sel == REG_CTRL) && byte_en[0];
        wr_period_s   = wr_en && (reg_sel == REG_PERIOD);
        wr_width_s    = wr_en && (reg_sel == REG_WIDTH);
        period_nz_s   = (period_r != P_ZERO);
        running_s     = loop_en_r && period_nz_s;
        fire_cmd_s    = wr_ctrl_s && wdata[CTRL_FIRE];
        loop_start_s  = wr_ctrl_s && wdata[CTRL_LOOP] && !loop_en_r;
        loop_stop_s   = wr_ctrl_s && !wdata[CTRL_LOOP];
        wrap_s        = running_s && tick && (phase_r == (period_r - P_ONE));
        loop_strike_s = (wrap_s && !loop_stop_s) || (loop_start_s && period_nz_s);
        fire_s        = fire_cmd_s || loop_strike_s;
        if (width_r == W_ZERO) begin
            load_s = W_ONE;
        end else begin
            load_s = width_r;
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loop_en_r <= 1'b0;
            period_r  <= P_ZERO;
            width_r   <= WIDTH_W'(DEF_WIDTH);
        end else begin
            if (wr_ctrl_s) begin
                loop_en_r <= wdata[CTRL_LOOP];
            end
            if (wr_period_s) begin
                period_r <= PERIOD_W'(be_merge(32'(period_r), wdata, byte_en));
            end
            if (wr_width_s) begin
                width_r <= WIDTH_W'(be_merge(32'(width_r), wdata, byte_en));
            end
        end
    end

    // Loop phase: restarts on loop start, on a PERIOD rewrite while running, and on wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r <= P_ZERO;
        end else if (loop_start_s || (wr_period_s && running_s) || !period_nz_s || wrap_s) begin
            phase_r <= P_ZERO;
        end else if (running_s && tick) begin
            phase_r <= phase_r + P_ONE;
        end
    end

    // Strike pulse FSM; a fire while ACTIVE reloads the counter so the output never gaps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= W_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fire_s) begin
                        state_r <= ACTIVE;
                        count_r <= load_s;
                    end
                end
                ACTIVE: begin
                    if (fire_s) begin
                        count_r <= load_s;
                    end else if (count_r <= W_ONE) begin
                        state_r <= IDLE;
                        count_r <= W_ZERO;
                    end else begin
                        count_r <= count_r - W_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= W_ZERO;
                end
            endcase
        end
    end

    assign strike = (state_r == ACTIVE);

`ifdef DRUM_IRQ_EN
    assign wr_status_s  = wr_en && (reg_sel == REG_STATUS);
    assign irq_en_eff_s = wr_ctrl_s ? wdata[CTRL_IRQ] : irq_en_r;

    // IRQ enable and pending flag; a strike in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_r  <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                irq_en_r <= wdata[CTRL_IRQ];
            end
            if (loop_strike_s && irq_en_eff_s) begin
                pending_r <= 1'b1;
            end else if (wr_status_s && wdata[STAT_PEND]) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign pending = pending_r;
`endif

    // Register read image for the selected offset.
    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            REG_CTRL: begin
                rd_data[CTRL_LOOP] = loop_en_r;
`ifdef DRUM_IRQ_EN
                rd_data[CTRL_IRQ]  = irq_en_r;
`endif
            end
            REG_PERIOD: rd_data = 32'(period_r);
            REG_WIDTH:  rd_data = 32'(width_r);
            REG_STATUS: begin
                rd_data[STAT_ACTIVE] = (state_r == ACTIVE);
                rd_data[STAT_RUN]    = running_s;
`ifdef DRUM_IRQ_EN
                rd_data[STAT_PEND]   = pending_r;
`endif
                rd_data[31:16]       = 16'(phase_r);
            end
            default: rd_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/drum_trigger_seq.sv
// Avalon-MM multi-channel drum trigger sequencer: shared tick prescaler, channel decode and read mux.
// Define DRUM_IRQ_EN to add the irq output and per-channel IRQ pending logic.
module drum_trigger_seq
    import drum_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CLK_DIV   = 50000,
    parameter int WIDTH_W   = 16,
    parameter int PERIOD_W  = 16,
    parameter int DEF_WIDTH = 40
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      AVL_READ,
    input  logic                      AVL_WRITE,
    input  logic                      AVL_CS,
    input  logic [3:0]                AVL_BYTE_EN,
    input  logic [$clog2(NUM_CH)+1:0] AVL_ADDR,
    input  logic [31:0]               AVL_WRITEDATA,
    output logic [31:0]               AVL_READDATA,
`ifdef DRUM_IRQ_EN
    output logic                      irq,
`endif
    output logic [NUM_CH-1:0]         GPIO
);

    localparam int ADDR_W = $clog2(NUM_CH) + 2;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PRE_W  = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};

    logic [PRE_W-1:0] presc_r;
    logic             tick_s;
    logic             wr_s;
    logic [CH_W-1:0]  ch_sel_s;
    logic [31:0]      ch_rd_s [NUM_CH];
    logic [31:0]      rd_mux_s;
`ifdef DRUM_IRQ_EN
    logic [NUM_CH-1:0] pend_s;
`endif

    assign tick_s = (presc_r == PRE_LAST);
    assign wr_s   = AVL_WRITE && AVL_CS;

    // Shared prescaler; tick is the wrap cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PRE_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRE_ONE;
        end
    end

    generate
        if (NUM_CH > 1) begin : g_sel
            assign ch_sel_s = AVL_ADDR[ADDR_W-1:2];
        end else begin : g_sel_one
            assign ch_sel_s = 1'b0;
        end
    endgenerate

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        drum_channel #(
            .WIDTH_W   (WIDTH_W),
            .PERIOD_W  (PERIOD_W),
            .DEF_WIDTH (DEF_WIDTH)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick_s),
            .wr_en   (wr_s && (ch_sel_s == CH_W'(i))),
            .reg_sel (AVL_ADDR[1:0]),
            .wdata   (AVL_WRITEDATA),
            .byte_en (AVL_BYTE_EN),
            .rd_data (ch_rd_s[i]),
`ifdef DRUM_IRQ_EN
            .pending (pend_s[i]),
`endif
            .strike  (GPIO[i])
        );
    end

    // Addressed channel's register image; channel slots beyond NUM_CH read 0.
    always_comb begin
        rd_mux_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_mux_s = rd_mux_s | ((ch_sel_s == CH_W'(i)) ? ch_rd_s[i] : 32'd0);
        end
    end

    // Registered read data with latency 1; holds between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            AVL_READDATA <= 32'd0;
        end else if (AVL_READ && AVL_CS) begin
            AVL_READDATA <= rd_mux_s;
        end
    end

`ifdef DRUM_IRQ_EN
    // Registered OR of all channel pending flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |pend_s;
        end
    end
`endif

endmodule

// File: tb/tb_drum_trigger_seq.sv
// Directed self-checking bench for drum_trigger_seq (NUM_CH=4, CLK_DIV=10); build with
// DRUM_IRQ_EN defined to also exercise the irq path.
module tb_drum_trigger_seq;
    import drum_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        avl_read = 1'b0;
    logic        avl_write = 1'b0;
    logic        avl_cs = 1'b0;
    logic [3:0]  avl_be = 4'h0;
    logic [3:0]  avl_addr = 4'h0;
    logic [31:0] avl_wdata = 32'h0;
    logic [31:0] avl_rdata;
    logic [3:0]  gpio;
`ifdef DRUM_IRQ_EN
    logic        irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    drum_trigger_seq #(
        .NUM_CH(4), .CLK_DIV(10), .WIDTH_W(16), .PERIOD_W(16), .DEF_WIDTH(40)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .AVL_READ      (avl_read),
        .AVL_WRITE     (avl_write),
        .AVL_CS        (avl_cs),
        .AVL_BYTE_EN   (avl_be),
        .AVL_ADDR      (avl_addr),
        .AVL_WRITEDATA (avl_wdata),
        .AVL_READDATA  (avl_rdata),
`ifdef DRUM_IRQ_EN
        .irq           (irq),
`endif
        .GPIO          (gpio)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] adr(input int ch, input logic [1:0] r);
        logic [1:0] c;
        c = ch[1:0];
        return {c, r};
    endfunction

    // All bus tasks start and end on a falling edge.
    task automatic avl_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        avl_write = 1'b1; avl_cs = 1'b1; avl_addr = a; avl_wdata = d; avl_be = be;
        @(negedge clk);
        avl_write = 1'b0; avl_cs = 1'b0; avl_be = 4'h0;
    endtask

    task automatic avl_rd(input logic [3:0] a, output logic [31:0] d);
        avl_read = 1'b1; avl_cs = 1'b1; avl_addr = a;
        @(negedge clk);
        avl_read = 1'b0; avl_cs = 1'b0;
        d = avl_rdata;
    endtask

    task automatic measure_high(input int ch, output int n);
        n = 0;
        while (gpio[ch] && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int n, hi, nrise, rise1, rise2, t;
        logic prev;
        logic [3:0] oth;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_val("rst_gpio", 32'(gpio), 32'h0);
        check_val("rst_rdata", avl_rdata, 32'h0);
`ifdef DRUM_IRQ_EN
        check_val("rst_irq", 32'(irq), 32'h0);
`endif
        avl_rd(adr(0, REG_WIDTH), rd);  check_val("rst_width", rd, 32'd40);
        avl_rd(adr(0, REG_PERIOD), rd); check_val("rst_period", rd, 32'd0);
        avl_rd(adr(0, REG_CTRL), rd);   check_val("rst_ctrl", rd, 32'd0);

        // Manual fire on ch1: exactly 40 cycles, other outputs quiet.
        avl_wr(adr(1, REG_CTRL), 32'h1, 4'hF);
        n = 0; oth = 4'h0;
        while (gpio[1] && n < 1000) begin
            n++;
            oth |= gpio & 4'b1101;
            @(negedge clk);
        end
        check_val("fire_len", 32'(n), 32'd40);
        check_val("fire_others", 32'(oth), 32'h0);
        avl_rd(adr(1, REG_CTRL), rd);   check_val("fire_reads0", rd, 32'h0);

        // Loop on ch0 with a short pulse so each strike is a separate rising edge.
        avl_wr(adr(0, REG_WIDTH), 32'd5, 4'hF);
        avl_wr(adr(0, REG_PERIOD), 32'd3, 4'hF);
        avl_wr(adr(0, REG_CTRL), 32'h2, 4'hF);
        check_val("loop_immediate", 32'(gpio[0]), 32'h1);
        t = 0; prev = 1'b1; nrise = 0; rise1 = 0; rise2 = 0;
        while (nrise < 2 && t < 200) begin
            @(negedge clk);
            t++;
            if (gpio[0] && !prev) begin
                nrise++;
                if (nrise == 1) rise1 = t; else rise2 = t;
            end
            prev = gpio[0];
        end
        check_val("loop_nrise", 32'(nrise), 32'd2);
        check_val("loop_first_gap_ok", 32'((rise1 >= 21) && (rise1 <= 30)), 32'h1);
        check_val("loop_period", 32'(rise2 - rise1), 32'd30);
        avl_rd(adr(0, REG_STATUS), rd); check_val("loop_running", 32'(rd[1]), 32'h1);
        avl_wr(adr(0, REG_PERIOD), 32'd0, 4'hF);
        nrise = 0; prev = gpio[0];
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gpio[0] && !prev) nrise++;
            prev = gpio[0];
        end
        check_val("loop_stopped", 32'(nrise), 32'd0);
        avl_rd(adr(0, REG_STATUS), rd); check_val("loop_status_idle", rd, 32'h0);
        avl_wr(adr(0, REG_CTRL), 32'h0, 4'hF);

        // Retrigger on ch2: FIRE at edge 0 and edge 50 -> high for cycles 1..150.
        avl_wr(adr(2, REG_WIDTH), 32'd100, 4'hF);
        avl_wr(adr(2, REG_CTRL), 32'h1, 4'hF);
        hi = gpio[2] ? 1 : 0;
        repeat (49) begin
            @(negedge clk);
            if (gpio[2]) hi++;
        end
        avl_wr(adr(2, REG_CTRL), 32'h1, 4'hF);
        measure_high(2, n);
        check_val("retrig_len", 32'(hi + n), 32'd150);

        // WIDTH=0 gives a one-cycle pulse.
        avl_wr(adr(3, REG_WIDTH), 32'd0, 4'hF);
        avl_wr(adr(3, REG_CTRL), 32'h1, 4'hF);
        measure_high(3, n);
        check_val("width0_len", 32'(n), 32'd1);

        // FIRE together with loop start is one 40-cycle pulse; clearing LOOP_EN lets it finish.
        avl_wr(adr(3, REG_WIDTH), 32'd40, 4'hF);
        avl_wr(adr(3, REG_PERIOD), 32'd3, 4'hF);
        avl_wr(adr(3, REG_CTRL), 32'h3, 4'hF);
        hi = gpio[3] ? 1 : 0;
        avl_wr(adr(3, REG_CTRL), 32'h0, 4'hF);
        measure_high(3, n);
        check_val("fire_loop_len", 32'(hi + n), 32'd40);
        oth = 4'h0;
        repeat (60) begin
            @(negedge clk);
            oth |= gpio;
        end
        check_val("loop_off_quiet", 32'(oth), 32'h0);

        // Byte enables, CTRL without byte 0, CS-low accesses.
        avl_wr(adr(3, REG_PERIOD), 32'h0000ABCD, 4'b0010);
        avl_rd(adr(3, REG_PERIOD), rd); check_val("be_period", rd, 32'h0000AB03);
        avl_wr(adr(3, REG_CTRL), 32'h1, 4'b1110);
        check_val("be_ctrl_ignored", 32'(gpio[3]), 32'h0);
        avl_write = 1'b1; avl_addr = adr(3, REG_CTRL); avl_wdata = 32'h1; avl_be = 4'hF;
        @(negedge clk);
        avl_write = 1'b0;
        check_val("cs_low_write", 32'(gpio[3]), 32'h0);
        avl_read = 1'b1; avl_addr = adr(0, REG_WIDTH);
        @(negedge clk);
        avl_read = 1'b0;
        check_val("cs_low_read_hold", avl_rdata, 32'h0000AB03);

        // IRQ_EN bit and STATUS writes.
        avl_wr(adr(0, REG_CTRL), 32'h4, 4'hF);
        avl_rd(adr(0, REG_CTRL), rd);
`ifdef DRUM_IRQ_EN
        check_val("ctrl_irq_bit", rd, 32'h4);
`else
        check_val("ctrl_irq_bit", rd, 32'h0);
`endif
        avl_wr(adr(0, REG_CTRL), 32'h0, 4'hF);
        avl_wr(adr(0, REG_STATUS), 32'hFFFFFFFF, 4'hF);
        avl_rd(adr(0, REG_STATUS), rd); check_val("status_wr", rd, 32'h0);

`ifdef DRUM_IRQ_EN
        avl_wr(adr(1, REG_PERIOD), 32'd2, 4'hF);
        avl_wr(adr(1, REG_CTRL), 32'h6, 4'hF);
        n = 0;
        while (!irq && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("irq_rise", 32'(irq), 32'h1);
        avl_rd(adr(1, REG_STATUS), rd); check_val("irq_pending", 32'(rd[2]), 32'h1);
        avl_wr(adr(1, REG_CTRL), 32'h4, 4'hF);
        avl_wr(adr(1, REG_STATUS), 32'h4, 4'hF);
        check_val("irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        check_val("irq_fall", 32'(irq), 32'h0);
        measure_high(1, n);
`endif

        // Reset mid-pulse drops GPIO at once and restores defaults.
        avl_wr(adr(2, REG_CTRL), 32'h1, 4'hF);
        repeat (5) @(negedge clk);
        check_val("pre_reset_high", 32'(gpio[2]), 32'h1);
        reset = 1'b1;
        #1;
        check_val("async_reset_gpio", 32'(gpio), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        oth = 4'h0;
        repeat (5) begin
            @(negedge clk);
            oth |= gpio;
        end
        check_val("post_reset_quiet", 32'(oth), 32'h0);
        avl_rd(adr(2, REG_WIDTH), rd); check_val("post_reset_width", rd, 32'd40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
